tt_um_guihca_multi: RTL and testbench

TT_UM_GUIHCA_MULTI -- requirements
Module: tt_um_guihca_multi

---
 rtl/tt_um_guihca_multi.sv | 180 ++++++++++++++++++
 tb/tb_tt_um_guihca_multi.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_guihca_multi.sv
// tt_um_guihca_multi: prescaled accumulator / serial bit capture / byte readback.
// A prescaler produces a tick every MAX_COUNT enabled cycles. The tick advances an
// 8-bit accumulator in ADD or COUNT mode. CAPTURE shifts ui_in[0] into a DEPTH-bit
// buffer, and READ shows one byte of that buffer on uo_out.
// Optional build macro GUIHCA_SEVENSEG_EN: in ADD/COUNT, uo_out carries a hex
// seven-segment pattern of acc[3:0] plus a decimal point that toggles on every tick.
// Interface handshake: there is no valid/ready pair. Inputs are sampled on every
// rising clk edge with ena=1, and uo_out is a pure combinational view of the registers.
module tt_um_guihca_multi #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
    parameter int          DEPTH     = 64
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {
        MODE_ADD     = 2'b00,
        MODE_COUNT   = 2'b01,
        MODE_CAPTURE = 2'b10,
        MODE_READ    = 2'b11
    } mode_t;

    // Last prescaler value; the tick fires while the counter holds it.
    localparam logic [23:0] PRESC_LAST = MAX_COUNT - 24'd1;
    // Index width for one bit of the capture buffer.
    localparam int          CAP_IW     = $clog2(DEPTH);
    // Pointer value of the final buffer slot; writing it sets full.
    localparam logic [6:0]  PTR_LAST   = 7'(DEPTH - 1);
    // Number of readable bytes in the buffer.
    localparam logic [3:0]  NBYTES     = 4'(DEPTH / 8);

    mode_t        w_mode;
    logic         w_clear;
    logic         w_tick;
    logic [23:0]  r_presc;
    logic [7:0]   r_acc;
    logic [DEPTH-1:0] r_cap;
    logic [6:0]   r_ptr;
    logic         r_full;
    logic [63:0]  w_cap64;
    logic [7:0]   w_read_byte;
    logic [7:0]   w_acc_disp;
    logic         w_unused;

    assign w_mode  = mode_t'(uio_in[1:0]);
    assign w_clear = uio_in[2];
    assign w_tick  = (r_presc == PRESC_LAST);

    // The bidirectional pins are always inputs.
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Reserved control bits are deliberately ignored.
    assign w_unused = &{1'b0, uio_in[7:3]};

    // Prescaler: free-runs in every mode while enabled, wraps after the tick.
    // A clear restarts the phase so the next tick is a full period away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 24'd0;
        end else if (ena) begin
            if (w_clear || w_tick) begin
                r_presc <= 24'd0;
            end else begin
                r_presc <= r_presc + 24'd1;
            end
        end
    end

    // Accumulator: on a tick, ADD sums ui_in and COUNT increments.
    // Clear takes priority over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 8'd0;
        end else if (ena) begin
            if (w_clear) begin
                r_acc <= 8'd0;
            end else if (w_tick) begin
                case (w_mode)
                    MODE_ADD:   r_acc <= r_acc + ui_in;
                    MODE_COUNT: r_acc <= r_acc + 8'd1;
                    default:    r_acc <= r_acc;
                endcase
            end
        end
    end

    // Capture: store one bit per enabled CAPTURE cycle until the buffer fills.
    // Once full, the buffer and pointer stay frozen until a clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap  <= '0;
            r_ptr  <= 7'd0;
            r_full <= 1'b0;
        end else if (ena) begin
            if (w_clear) begin
                r_cap  <= '0;
                r_ptr  <= 7'd0;
                r_full <= 1'b0;
            end else if (w_mode == MODE_CAPTURE && !r_full) begin
                r_cap[r_ptr[CAP_IW-1:0]] <= ui_in[0];
                r_ptr <= r_ptr + 7'd1;
                if (r_ptr == PTR_LAST) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

    // Byte readback: indices past the end of the buffer read as zero.
    assign w_cap64 = 64'(r_cap);
    always_comb begin
        w_read_byte = 8'h00;
        if ({1'b0, ui_in[2:0]} < NBYTES) begin
            w_read_byte = w_cap64[{ui_in[2:0], 3'b000} +: 8];
        end
    end

`ifdef GUIHCA_SEVENSEG_EN
    logic       r_dp;
    logic [6:0] w_seg;

    // Decimal point: toggles on every tick that is not overridden by a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp <= 1'b0;
        end else if (ena && !w_clear && w_tick) begin
            r_dp <= ~r_dp;
        end
    end

    // Hex to seven-segment decode of the low accumulator nibble, bit order gfedcba.
    always_comb begin
        w_seg = 7'h00;
        case (r_acc[3:0])
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            4'hF: w_seg = 7'h71;
            default: w_seg = 7'h00;
        endcase
    end

    assign w_acc_disp = {r_dp, w_seg};
`else
    assign w_acc_disp = r_acc;
`endif

    // Output select: only the view changes with the mode; the state is untouched.
    always_comb begin
        uo_out = 8'h00;
        case (w_mode)
            MODE_ADD,
            MODE_COUNT:   uo_out = w_acc_disp;
            MODE_CAPTURE: uo_out = {r_full, r_ptr};
            MODE_READ:    uo_out = w_read_byte;
            default:      uo_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tt_um_guihca_multi.sv
// Bench for tt_um_guihca_multi with MAX_COUNT=4, DEPTH=16, default (raw acc) build.
module tb_tt_um_guihca_multi;

  localparam logic [23:0] MC    = 24'd4;
  localparam int          DEPTH = 16;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_q[$];

  tt_um_guihca_multi #(
    .MAX_COUNT(MC),
    .DEPTH(DEPTH)
  ) dut (
    .ui_in(ui_in),
    .uo_out(uo_out),
    .uio_in(uio_in),
    .uio_out(uio_out),
    .uio_oe(uio_oe),
    .ena(ena),
    .clk(clk),
    .rst_n(rst_n)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // checker
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard
  task automatic push_exp(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_out(input string tag);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got empty queue expected entry", tag);
    end else begin
      chk(tag, uo_out, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] ctl, input logic [7:0] d);
    uio_in = {5'b00000, ctl};
    ui_in  = d;
  endtask

  task automatic do_clear(input logic [1:0] mode);
    set_in({1'b1, mode}, 8'h00);
    step(1);
    uio_in[2] = 1'b0;
  endtask

  logic [15:0] pat;
  logic [7:0]  acc_m;
  logic [23:0] presc_m;
  logic [1:0]  rmode;
  logic [7:0]  rdata;
  logic        rclr;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ena   = 1'b1;
    rst_n = 1'b0;
    set_in(3'b001, 8'h00);
    #12;
    push_exp(8'h00); check_out("reset_out");
    chk("uio_out", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;

    // COUNT from reset: ticks at edges 4, 8, 12
    step(11);
    push_exp(8'h02); check_out("count_11");
    step(1);
    push_exp(8'h03); check_out("count_12");

    // ADD 0xF0 with wrap
    do_clear(2'b00);
    set_in(3'b000, 8'hF0);
    step(4);  push_exp(8'hF0); check_out("add_t1");
    step(4);  push_exp(8'hE0); check_out("add_t2");
    step(4);  push_exp(8'hD0); check_out("add_t3");

    // ena=0 freezes state and ignores clear
    do_clear(2'b01);
    set_in(3'b001, 8'h00);
    step(6);
    push_exp(8'h01); check_out("pre_freeze");
    ena = 1'b0;
    uio_in[2] = 1'b1;
    step(10);
    push_exp(8'h01); check_out("freeze");
    uio_in[2] = 1'b0;
    ena = 1'b1;
    step(2);
    push_exp(8'h02); check_out("thaw_phase");

    // clear coincident with a tick at acc=5
    do_clear(2'b01);
    set_in(3'b001, 8'h00);
    step(23);
    push_exp(8'h05); check_out("acc5");
    uio_in[2] = 1'b1;
    step(1);
    uio_in[2] = 1'b0;
    push_exp(8'h00); check_out("clr_tick");
    step(3);
    push_exp(8'h00); check_out("clr_no_tick");
    step(1);
    push_exp(8'h01); check_out("clr_next_tick");

    // CAPTURE pattern, then overflow cycles
    do_clear(2'b10);
    pat = 16'h0F0D;
    for (int i = 0; i < 16; i++) begin
      set_in(3'b010, {7'b0000000, pat[i]});
      step(1);
      if (i == 6) begin
        push_exp(8'h07); check_out("cap_ptr7");
      end
    end
    push_exp(8'h90); check_out("cap_full");
    set_in(3'b010, 8'hFF);
    step(3);
    push_exp(8'h90); check_out("cap_hold");

    // READ bytes
    set_in(3'b011, 8'h00); #1; push_exp(8'h0D); check_out("read_k0");
    set_in(3'b011, 8'h01); #1; push_exp(8'h0F); check_out("read_k1");
    set_in(3'b011, 8'h02); #1; push_exp(8'h00); check_out("read_k2");
    set_in(3'b011, 8'h07); #1; push_exp(8'h00); check_out("read_k7");
    set_in(3'b010, 8'h00); #1; push_exp(8'h90); check_out("mode_keep");

    // random ADD/COUNT traffic against a reference model
    do_clear(2'b00);
    acc_m   = 8'h00;
    presc_m = 24'd0;
    for (int i = 0; i < 40; i++) begin
      rmode = 2'($urandom_range(0, 1));
      rdata = 8'($urandom_range(0, 255));
      rclr  = ($urandom_range(0, 7) == 0);
      set_in({rclr, rmode}, rdata);
      if (rclr) begin
        acc_m   = 8'h00;
        presc_m = 24'd0;
      end else if (presc_m == MC - 24'd1) begin
        acc_m   = (rmode == 2'b01) ? acc_m + 8'h01 : acc_m + rdata;
        presc_m = 24'd0;
      end else begin
        presc_m = presc_m + 24'd1;
      end
      push_exp(acc_m);
      step(1);
      check_out("rand");
    end

    // async reset mid-capture
    do_clear(2'b10);
    for (int i = 0; i < 7; i++) begin
      set_in(3'b010, 8'($urandom_range(0, 1)));
      step(1);
    end
    push_exp(8'h07); check_out("cap_pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(8'h00); check_out("async_rst");
    set_in(3'b001, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    push_exp(8'h00); check_out("rst_no_tick");
    step(1);
    push_exp(8'h01); check_out("rst_first_tick");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
